// File: rtl/tensor_core_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tensor_core_pkg : shared widths, FSM state type and saturation helpers
// Revision: 1.0
// ----------------------------------------------------------------------------
package tensor_core_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 18;
  localparam int NUM_SLOTS  = 2;
  localparam int MATRIX_DIM = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTE   = 2'd1,
    WRITEBACK = 2'd2
  } state_e;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  // Bitwise inversion of the positive limit yields the negative limit.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic saturates(input logic signed [ACC_WIDTH-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tensor_core_dot4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tensor_core_dot4 : 4-term signed dot product saturated to DATA_WIDTH
// Revision: 1.0
// ----------------------------------------------------------------------------
module tensor_core_dot4
  import tensor_core_pkg::saturate, tensor_core_pkg::saturates;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input  logic [3:0][DATA_WIDTH-1:0] a_i,
  input  logic [3:0][DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0]      result_o,
  output logic                       saturated_o
);

  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [2*DATA_WIDTH-1:0] a_ext;
  logic signed [2*DATA_WIDTH-1:0] b_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    acc   = '0;
    a_ext = '0;
    b_ext = '0;
    prod  = '0;
    for (int k = 0; k < 4; k++) begin
      a_ext = {{DATA_WIDTH{a_i[k][DATA_WIDTH-1]}}, a_i[k]};
      b_ext = {{DATA_WIDTH{b_i[k][DATA_WIDTH-1]}}, b_i[k]};
      prod  = a_ext * b_ext;
      acc   = acc + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    end
  end

  assign result_o    = saturate(acc);
  assign saturated_o = saturates(acc);

endmodule
`default_nettype wire

// File: rtl/tensor_core_matmul.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tensor_core_matmul : C = A x B over the register-file slots, one row/cycle
// Revision: 1.0
// ----------------------------------------------------------------------------
module tensor_core_matmul
  import tensor_core_pkg::NUM_SLOTS, tensor_core_pkg::MATRIX_DIM;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic start_in,
  input  logic [NUM_SLOTS-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] operand_data_in,
  output logic busy_out,
  output logic done_out,
  output logic overflow_out,
  output logic bulk_write_enable_out,
  output logic [NUM_SLOTS-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] bulk_write_data_out
);

  import tensor_core_pkg::state_e;
  import tensor_core_pkg::IDLE;
  import tensor_core_pkg::COMPUTE;
  import tensor_core_pkg::WRITEBACK;

  state_e                                              state_q;
  logic [1:0]                                          row_q;
  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] a_q;
  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] b_q;
  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] c_q;
  logic                                                overflow_q;

  logic [MATRIX_DIM-1:0][DATA_WIDTH-1:0] row_result;
  logic [MATRIX_DIM-1:0]                 row_sat;

  for (genvar j = 0; j < MATRIX_DIM; j++) begin : g_col
    logic [MATRIX_DIM-1:0][DATA_WIDTH-1:0] b_col;
    for (genvar k = 0; k < MATRIX_DIM; k++) begin : g_k
      assign b_col[k] = b_q[k][j];
    end
    tensor_core_dot4 #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_dot4 (
      .a_i         (a_q[row_q]),
      .b_i         (b_col),
      .result_o    (row_result[j]),
      .saturated_o (row_sat[j])
    );
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      row_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        // WRITEBACK is the cycle the FSM returns to IDLE, so a start seen
        // there is accepted immediately for back-to-back 5-cycle throughput.
        IDLE, WRITEBACK: begin
          if (start_in) begin
            state_q    <= COMPUTE;
            row_q      <= '0;
            a_q        <= operand_data_in[0];
            b_q        <= operand_data_in[1];
            c_q        <= '0;
            overflow_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        COMPUTE: begin
          c_q[row_q] <= row_result;
          if (|row_sat) overflow_q <= 1'b1;
          row_q <= row_q + 2'd1;
          if (row_q == 2'd3) state_q <= WRITEBACK;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_out               = (state_q != IDLE);
  assign done_out               = (state_q == WRITEBACK);
  assign bulk_write_enable_out  = (state_q == WRITEBACK);
  assign overflow_out           = overflow_q;
  assign bulk_write_data_out[0] = c_q;
  assign bulk_write_data_out[1] = b_q;

endmodule
`default_nettype wire
